// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit path: per-lane retire record, stored FIFO entry,
// and a popcount helper used to size each commit group.
package difftest_pkg;

   typedef struct packed {
      logic        commit;
      logic        skip;
      logic [31:0] pc;
      logic [31:0] inst;
   } difftest_info_t;

   typedef struct packed {
      logic        skip;
      logic [31:0] pc;
      logic [31:0] inst;
   } difftest_entry_t;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 32; i++) begin
         c += {31'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/difftest_compact.sv
// Packs the committing lanes of one retire group into consecutive slots, oldest lane first,
// and reports how many slots are valid.
module difftest_compact
   import difftest_pkg::*;
#(
   parameter int NRET = 2
) (
   input  difftest_info_t                 diff_i   [NRET],
   output difftest_entry_t                packed_o [NRET],
   output logic [$clog2(NRET+1)-1:0]      n_o
);

   localparam int NW = $clog2(NRET + 1);

   logic [31:0] cvec;
   int          pos [NRET];

   always_comb begin
      cvec = '0;
      for (int l = 0; l < NRET; l++) begin
         cvec[l] = diff_i[l].commit;
      end
      n_o = NW'(popcount(cvec));
   end

   // Slot of each lane = number of committing lanes below it.
   always_comb begin
      for (int l = 0; l < NRET; l++) begin
         pos[l] = 0;
         for (int k = 0; k < l; k++) begin
            pos[l] += diff_i[k].commit ? 1 : 0;
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NRET; j++) begin
         packed_o[j] = '0;
         for (int l = 0; l < NRET; l++) begin
            if (diff_i[l].commit && (pos[l] == j)) begin
               packed_o[j] = '{skip: diff_i[l].skip, pc: diff_i[l].pc, inst: diff_i[l].inst};
            end
         end
      end
   end

endmodule

// File: rtl/difftest_commit_buffer.sv
// Multi-lane commit collector: compacts retire groups into a FIFO drained one entry per cycle,
// with a retired counter, sticky overflow on dropped groups, and a commit-stall watchdog.
module difftest_commit_buffer
   import difftest_pkg::*;
#(
   parameter int NRET    = 2,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 5000,
   parameter int CNT_W   = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  difftest_info_t           diff [NRET],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic                     out_skip,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         retired,
   output logic                     overflow,
   output logic                     timeout
);

   localparam int PW   = $clog2(DEPTH);
   localparam int OW   = PW + 1;
   localparam int NW   = $clog2(NRET + 1);
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   difftest_entry_t   grp [NRET];
   logic [NW-1:0]     n;

   difftest_compact #(.NRET(NRET)) u_compact (
      .diff_i   (diff),
      .packed_o (grp),
      .n_o      (n)
   );

   difftest_entry_t   mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]     occ_q, occ_d, free;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              ovf_q, ovf_d, to_q, to_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              push_ok, pop, accepted;

   // Free space ignores a same-cycle pop, so a full FIFO never accepts a group.
   always_comb begin
      free      = OW'(DEPTH) - occ_q;
      push_ok   = OW'(n) <= free;
      pop       = (occ_q != '0) && out_ready;
      accepted  = push_ok && (n != '0);
      wr_ptr_d  = push_ok ? wr_ptr_q + PW'(n) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      occ_d     = occ_q + (push_ok ? OW'(n) : '0) - (pop ? OW'(1) : '0);
      retired_d = push_ok ? retired_q + CNT_W'(n) : retired_q;
      ovf_d     = ovf_q | ~push_ok;
      wd_d      = '0;
      to_d      = to_q;
      if (TIMEOUT != 0) begin
         if (accepted)            wd_d = '0;
         else if (wd_q == WD_MAX) wd_d = wd_q;
         else                     wd_d = wd_q + WD_W'(1);
         to_d = to_q | (wd_d == WD_MAX);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         retired_q <= '0;
         ovf_q     <= 1'b0;
         to_q      <= 1'b0;
         wd_q      <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         retired_q <= retired_d;
         ovf_q     <= ovf_d;
         to_q      <= to_d;
         wd_q      <= wd_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         for (int k = 0; k < NRET; k++) begin
            if (NW'(k) < n) mem_q[wr_ptr_q + PW'(k)] <= grp[k];
         end
      end
   end

   assign out_valid = (occ_q != '0);
   assign out_pc    = mem_q[rd_ptr_q].pc;
   assign out_inst  = mem_q[rd_ptr_q].inst;
   assign out_skip  = mem_q[rd_ptr_q].skip;
   assign occupancy = occ_q;
   assign retired   = retired_q;
   assign overflow  = ovf_q;
   assign timeout   = to_q;

endmodule
